// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard controller: hazard sources in,
// stall/flush/forward controls and status out.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_Rs1D;
    logic [4:0]       i_Rs2D;
    logic [4:0]       i_Rs1E;
    logic [4:0]       i_Rs2E;
    logic [4:0]       i_RdE;
    logic [4:0]       i_RdM;
    logic [4:0]       i_RdW;
    logic             i_PCSrcE;
    logic             i_ResultSrcE_0;
    logic             i_RegWriteM;
    logic             i_RegWriteW;
    logic             i_MemReqM;
    logic             i_MemAckM;
    logic             i_CountClr;

    logic             o_StallF;
    logic             o_StallD;
    logic             o_StallE;
    logic             o_StallM;
    logic             o_FlushD;
    logic             o_FlushE;
    logic             o_FlushW;
    logic [1:0]       o_ForwardAE;
    logic [1:0]       o_ForwardBE;
    logic [CNT_W-1:0] o_StallCount;
    logic [CNT_W-1:0] o_FlushCount;
    logic             o_MemError;

    modport master (
        output i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW,
               i_PCSrcE, i_ResultSrcE_0, i_RegWriteM, i_RegWriteW,
               i_MemReqM, i_MemAckM, i_CountClr,
        input  o_StallF, o_StallD, o_StallE, o_StallM,
               o_FlushD, o_FlushE, o_FlushW,
               o_ForwardAE, o_ForwardBE,
               o_StallCount, o_FlushCount, o_MemError
    );

    modport slave (
        input  i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW,
               i_PCSrcE, i_ResultSrcE_0, i_RegWriteM, i_RegWriteW,
               i_MemReqM, i_MemAckM, i_CountClr,
        output o_StallF, o_StallD, o_StallE, o_StallM,
               o_FlushD, o_FlushE, o_FlushW,
               o_ForwardAE, o_ForwardBE,
               o_StallCount, o_FlushCount, o_MemError
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I core: stalls, flushes, forwarding,
// data-memory wait states, performance counters and a sticky memory timeout.
//
// state    | meaning
// IDLE     | no outstanding data-memory access beyond the current cycle
// MEM_WAIT | access issued earlier, pipeline held until i_MemAckM
module hazard_ctrl_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    hazard_ctrl_unit_if.slave if_haz
);
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_mem_stall_raw;
    logic             w_mem_stall;
    logic             w_lw_stall;
    logic             w_stall_fd;
    logic             w_flush_d;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_cnt_inc;
    logic             w_wait_tick;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_stall_raw = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_haz.i_MemReqM && !if_haz.i_MemAckM) begin
                    w_state_nxt     = MEM_WAIT;
                    w_mem_stall_raw = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (if_haz.i_MemAckM)
                    w_state_nxt = IDLE;
                else
                    w_mem_stall_raw = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset gates every control output, including the purely input-driven ones.
    assign w_mem_stall = i_Reset_n & w_mem_stall_raw;
    assign w_lw_stall  = i_Reset_n & if_haz.i_ResultSrcE_0 & (if_haz.i_RdE != 5'd0) &
                         ((if_haz.i_Rs1D == if_haz.i_RdE) | (if_haz.i_Rs2D == if_haz.i_RdE));
    assign w_stall_fd  = w_lw_stall | w_mem_stall;
    assign w_flush_d   = i_Reset_n & if_haz.i_PCSrcE & ~w_mem_stall;

    assign if_haz.o_StallF = w_stall_fd;
    assign if_haz.o_StallD = w_stall_fd;
    assign if_haz.o_StallE = w_mem_stall;
    assign if_haz.o_StallM = w_mem_stall;
    assign if_haz.o_FlushW = w_mem_stall;
    assign if_haz.o_FlushD = w_flush_d;
    assign if_haz.o_FlushE = i_Reset_n & (w_lw_stall | if_haz.i_PCSrcE) & ~w_mem_stall;

    assign if_haz.o_ForwardAE = i_Reset_n ?
        fwd_sel(if_haz.i_Rs1E, if_haz.i_RegWriteM, if_haz.i_RdM, if_haz.i_RegWriteW, if_haz.i_RdW) :
        2'b00;
    assign if_haz.o_ForwardBE = i_Reset_n ?
        fwd_sel(if_haz.i_Rs2E, if_haz.i_RegWriteM, if_haz.i_RdM, if_haz.i_RegWriteW, if_haz.i_RdW) :
        2'b00;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (if_haz.i_CountClr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_fd && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_d && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    // Counts un-acked MEM_WAIT cycles; the error lands on the edge ending the
    // MEM_TIMEOUT-th one.
    assign w_wait_tick    = (r_state == MEM_WAIT) && !if_haz.i_MemAckM;
    assign w_wait_cnt_inc = r_wait_cnt + 16'd1;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            if ((r_state == IDLE) && (w_state_nxt == MEM_WAIT))
                r_wait_cnt <= '0;
            else if (w_wait_tick && (r_wait_cnt != WAIT_LIMIT))
                r_wait_cnt <= w_wait_cnt_inc;
            if (w_wait_tick && (w_wait_cnt_inc == WAIT_LIMIT))
                r_mem_error <= 1'b1;
        end
    end

    assign if_haz.o_StallCount = r_stall_cnt;
    assign if_haz.o_FlushCount = r_flush_cnt;
    assign if_haz.o_MemError   = r_mem_error;
endmodule
